ram_reader: RTL and testbench

RAM_READER -- requirements
Module: ram_reader

---
 rtl/ram_reader.sv | 170 +++++++++++++++++
 tb/tb_ram_reader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_reader.sv
// ram_reader: scans a single-port synchronous RAM one word at a time and
// services 4-phase write requests. Writes have priority over reads.
// Scans are paced by a DIV-cycle tick when run=1, or by step rising edges
// when run=0.
// Optional feature: define RAM_READER_CHECKSUM_EN to produce a per-pass sum
// of the words read.
module ram_reader #(
  parameter int unsigned DIV    = 50000000,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 4
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     run,
  input  logic                     step,
  input  logic                     wr_req,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ack,
  output logic [ADDR_W-1:0]        ram_address,
  output logic [DATA_W-1:0]        ram_data,
  output logic                     ram_wren,
  input  logic [DATA_W-1:0]        ram_q,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     pass_done,
  output logic [ADDR_W+DATA_W-1:0] checksum
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SUM_W = ADDR_W + DATA_W;

  typedef enum logic [2:0] {IDLE, READ, CAPT, WRITE, WACK} state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  tick_cnt;
  logic              tick;
  logic              step_q;
  logic              step_rise;
  logic              pending;
  logic [ADDR_W-1:0] scan_ptr, scan_ptr_d;
  logic              capture;
  logic              last_word;
  logic [ADDR_W-1:0] ram_address_d;
  logic [DATA_W-1:0] ram_data_d;
  logic              ram_wren_d;
  logic              wr_ack_d;

  assign tick      = run && (tick_cnt == CNT_W'(DIV - 1));
  assign step_rise = step && !step_q;
  assign capture   = (state == CAPT);
  assign last_word = (scan_ptr == {ADDR_W{1'b1}});

  // Scan pacing counter: free-runs 0..DIV-1 while run=1, held at 0 otherwise
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tick_cnt <= '0;
    end else if (!run || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  // Step edge history and single-entry read request flag
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      step_q  <= 1'b0;
      pending <= 1'b0;
    end else begin
      step_q <= step;
      if (state_d == READ) begin
        pending <= 1'b0;
      end else if (tick || (step_rise && !run)) begin
        pending <= 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      scan_ptr <= '0;
    end else begin
      state    <= state_d;
      scan_ptr <= scan_ptr_d;
    end
  end

  // Next state, scan pointer and next values of the RAM-side outputs
  always_comb begin
    state_d    = state;
    scan_ptr_d = scan_ptr;
    unique case (state)
      IDLE: begin
        if (wr_req) begin
          state_d = WRITE;
        end else if (pending) begin
          state_d = READ;
        end
      end
      READ:  state_d = CAPT;
      CAPT: begin
        state_d    = IDLE;
        scan_ptr_d = scan_ptr + ADDR_W'(1);
      end
      WRITE: state_d = WACK;
      WACK: begin
        if (!wr_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    ram_wren_d    = (state_d == WRITE);
    wr_ack_d      = (state_d == WACK);
    ram_address_d = ram_wren_d ? wr_addr : scan_ptr_d;
    ram_data_d    = ram_wren_d ? wr_data : '0;
  end

  // Registered outputs, aligned with the state they belong to
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
      wr_ack      <= 1'b0;
      rd_addr     <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      pass_done   <= 1'b0;
    end else begin
      ram_address <= ram_address_d;
      ram_data    <= ram_data_d;
      ram_wren    <= ram_wren_d;
      wr_ack      <= wr_ack_d;
      rd_valid    <= capture;
      pass_done   <= capture && last_word;
      if (capture) begin
        rd_addr <= scan_ptr;
        rd_data <= ram_q;
      end
    end
  end

`ifdef RAM_READER_CHECKSUM_EN
  logic [SUM_W-1:0] acc;

  // Per-pass sum; published together with pass_done
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      acc      <= '0;
      checksum <= '0;
    end else if (capture) begin
      if (last_word) begin
        checksum <= acc + SUM_W'(ram_q);
        acc      <= '0;
      end else begin
        acc <= acc + SUM_W'(ram_q);
      end
    end
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_ram_reader.sv
// Bench for ram_reader: per-cycle vector table for step reads and writes,
// plus hand sequences for auto scan, write/tick collision and mid-handshake
// reset. Includes a behavioural synchronous RAM.
module tb_ram_reader;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned NVEC   = 25;

  logic              clock;
  logic              resetn;
  logic              run;
  logic              step;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              pass_done;
  logic [ADDR_W+DATA_W-1:0] checksum;

  int tests;
  int fails;

  ram_reader #(.DIV(4), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .resetn(resetn), .run(run), .step(step),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .pass_done(pass_done), .checksum(checksum)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous RAM: registered address, unregistered q; load_pat fills word i = i[3:0]
  logic [DATA_W-1:0] mem [32];
  logic [ADDR_W-1:0] q_addr;
  logic              load_pat;

  always_ff @(posedge clock) begin
    if (load_pat) begin
      for (int i = 0; i < 32; i++) mem[i] <= DATA_W'(i);
    end else if (ram_wren) begin
      mem[ram_address] <= ram_data;
    end
    q_addr <= ram_address;
  end
  assign ram_q = mem[q_addr];

  typedef struct {
    logic              step;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [20:0]       exp;   // {ram_wren, ram_address, ram_data, wr_ack, rd_valid, rd_addr, rd_data}
  } vec_t;

  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic s, input logic wq, input int wa, input int wd,
                              input logic e_wren, input int e_ra, input int e_rdat,
                              input logic e_ack, input logic e_rv, input int e_rda,
                              input int e_rdd);
    vec_t v;
    v.step    = s;
    v.wr_req  = wq;
    v.wr_addr = ADDR_W'(wa);
    v.wr_data = DATA_W'(wd);
    v.exp     = {e_wren, ADDR_W'(e_ra), DATA_W'(e_rdat), e_ack, e_rv,
                 ADDR_W'(e_rda), DATA_W'(e_rdd)};
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({ram_wren, wr_ack, rd_valid, pass_done, rd_addr, rd_data,
                ram_address, ram_data, checksum});
  endfunction

  task automatic tick_clk();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic with_load);
    resetn   = 1'b0;
    load_pat = with_load;
    repeat (3) tick_clk();
    load_pat = 1'b0;
    resetn   = 1'b1;
  endtask

  task automatic wait_read(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick_clk();
      if (rd_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  logic [ADDR_W+DATA_W-1:0] exp_sum;
  bit ok;

  initial begin
    tests = 0; fails = 0;
    resetn = 1'b0; run = 1'b0; step = 1'b0; wr_req = 1'b0;
    wr_addr = '0; wr_data = '0; load_pat = 1'b0;
`ifdef RAM_READER_CHECKSUM_EN
    exp_sum = (ADDR_W+DATA_W)'(240);
`else
    exp_sum = '0;
`endif

    // Step reads, a write, then a write to the next scan address read back
    vecs[0]  = mk(1, 0, 0, 0,    0, 0, 0,    0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0,    0, 0, 0,    0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0,    0, 0, 0,    0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0,    0, 1, 0,    0, 1, 0, 0);
    vecs[4]  = mk(1, 0, 0, 0,    0, 1, 0,    0, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0,    0, 1, 0,    0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0,    0, 1, 0,    0, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0,    0, 2, 0,    0, 1, 1, 1);
    vecs[8]  = mk(1, 0, 0, 0,    0, 2, 0,    0, 0, 1, 1);
    vecs[9]  = mk(1, 0, 0, 0,    0, 2, 0,    0, 0, 1, 1);
    vecs[10] = mk(1, 0, 0, 0,    0, 2, 0,    0, 0, 1, 1);
    vecs[11] = mk(1, 0, 0, 0,    0, 3, 0,    0, 1, 2, 2);
    vecs[12] = mk(1, 0, 0, 0,    0, 3, 0,    0, 0, 2, 2);
    vecs[13] = mk(0, 1, 5, 'hA,  1, 5, 'hA,  0, 0, 2, 2);
    vecs[14] = mk(0, 1, 5, 'hA,  0, 3, 0,    1, 0, 2, 2);
    vecs[15] = mk(0, 1, 5, 'hA,  0, 3, 0,    1, 0, 2, 2);
    vecs[16] = mk(0, 0, 0, 0,    0, 3, 0,    0, 0, 2, 2);
    vecs[17] = mk(0, 0, 0, 0,    0, 3, 0,    0, 0, 2, 2);
    vecs[18] = mk(0, 1, 3, 9,    1, 3, 9,    0, 0, 2, 2);
    vecs[19] = mk(0, 1, 3, 9,    0, 3, 0,    1, 0, 2, 2);
    vecs[20] = mk(0, 0, 0, 0,    0, 3, 0,    0, 0, 2, 2);
    vecs[21] = mk(1, 0, 0, 0,    0, 3, 0,    0, 0, 2, 2);
    vecs[22] = mk(0, 0, 0, 0,    0, 3, 0,    0, 0, 2, 2);
    vecs[23] = mk(0, 0, 0, 0,    0, 3, 0,    0, 0, 2, 2);
    vecs[24] = mk(0, 0, 0, 0,    0, 4, 0,    0, 1, 3, 9);

    // Reset values
    resetn = 1'b0; load_pat = 1'b1;
    repeat (3) tick_clk();
    check("reset_outputs", all_outs(), 64'd0);
    load_pat = 1'b0;
    resetn = 1'b1;

    // Vector table, run=0
    for (int k = 0; k < int'(NVEC); k++) begin
      step    = vecs[k].step;
      wr_req  = vecs[k].wr_req;
      wr_addr = vecs[k].wr_addr;
      wr_data = vecs[k].wr_data;
      tick_clk();
      check($sformatf("vec%0d", k),
            64'({ram_wren, ram_address, ram_data, wr_ack, rd_valid, rd_addr, rd_data}),
            64'(vecs[k].exp));
    end
    step = 1'b0; wr_req = 1'b0;

    // Automatic scan with DIV=4: a full pass plus wrap
    run = 1'b1;
    do_reset(1'b1);
    begin
      int nreads;
      int last_cyc;
      nreads = 0;
      last_cyc = 0;
      for (int cyc = 0; cyc < 300 && nreads < 33; cyc++) begin
        tick_clk();
        if (rd_valid) begin
          check($sformatf("scan_read%0d", nreads),
                64'({rd_addr, rd_data, pass_done}),
                64'({ADDR_W'(nreads % 32), DATA_W'(nreads % 16), nreads == 31}));
          if (nreads > 0) check($sformatf("scan_interval%0d", nreads),
                                64'(cyc - last_cyc), 64'd4);
          if (nreads == 31) check("checksum_pass", 64'(checksum), 64'(exp_sum));
          last_cyc = cyc;
          nreads++;
        end else begin
          if (pass_done) check("pass_done_without_valid", 64'(pass_done), 64'd0);
        end
      end
      if (nreads < 33) check("scan_timeout", 64'(nreads), 64'd33);
    end

    // Write request coincident with a tick: write first, then the pending read
    run = 1'b1;
    do_reset(1'b1);
    repeat (3) tick_clk();
    wr_req = 1'b1; wr_addr = '0; wr_data = DATA_W'(7);
    tick_clk();
    run = 1'b0;
    check("collide_write", 64'({ram_wren, ram_address, ram_data}),
          64'({1'b1, ADDR_W'(0), DATA_W'(7)}));
    tick_clk();
    check("collide_ack", 64'({wr_ack, ram_wren, rd_valid}), 64'({1'b1, 1'b0, 1'b0}));
    tick_clk();
    wr_req = 1'b0;
    wait_read(20, ok);
    check("collide_read_seen", 64'(ok), 64'd1);
    check("collide_read", 64'({rd_addr, rd_data}), 64'({ADDR_W'(0), DATA_W'(7)}));

    // Reset during WACK drops the handshake at once; scan restarts at 0
    wr_req = 1'b1; wr_addr = ADDR_W'(2); wr_data = DATA_W'(3);
    tick_clk();
    check("rst_wack_write", 64'(ram_wren), 64'd1);
    tick_clk();
    check("rst_wack_ack", 64'(wr_ack), 64'd1);
    resetn = 1'b0;
    #1;
    check("rst_wack_async", all_outs(), 64'd0);
    wr_req = 1'b0;
    tick_clk();
    check("rst_wack_held", all_outs(), 64'd0);
    resetn = 1'b1;
    step = 1'b1;
    tick_clk();
    step = 1'b0;
    wait_read(20, ok);
    check("rst_read_seen", 64'(ok), 64'd1);
    check("rst_read_addr0", 64'({rd_addr, rd_data}), 64'({ADDR_W'(0), DATA_W'(7)}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
